universal_shift_reg: RTL and testbench

- Parametrised successor to the 4-bit hold/complement/shift register. WIDTH-bit register with eight operations, including parallel load, rotate and arithmetic shift.
- Multi-step shifts of 0..WIDTH positions run one step per clock, under a valid/ready command handshake with busy/done status.
- Used as a datapath shift/rotate unit and as a serial-stream front end, via shift_in_R/shift_in_L and the serial outputs.

---
 rtl/shift_reg_pkg.sv | 27 ++
 rtl/shift_step_logic.sv | 36 +++
 rtl/universal_shift_reg.sv | 109 ++++++++++
 tb/tb_universal_shift_reg.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register.
// Contents:
//   - op-code constants OP_HOLD..OP_LOAD
//   - amt_width(): step-count field width for a given register width
//   - is_step_op(): true for ops that run one step per clock
package shift_reg_pkg;

    // Codes 000-011 keep the legacy 2-bit hold/complement/shift encoding.
    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_COMP = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_LOAD = 3'b111;

    // Enough bits to hold every count from 0 to width inclusive.
    function automatic int unsigned amt_width(int unsigned width);
        return $clog2(width + 1);
    endfunction

    function automatic logic is_step_op(logic [2:0] op);
        return (op != OP_HOLD) && (op != OP_COMP) && (op != OP_LOAD);
    endfunction

endpackage

// File: rtl/shift_step_logic.sv
// Combinational next-value logic for one step of the universal shift register.
// Ports:
//   q_i           current register contents
//   op_i          operation code (shift_reg_pkg OP_*)
//   shift_in_r_i  bit entering the MSB on SHR
//   shift_in_l_i  bit entering the LSB on SHL
//   load_data_i   parallel load value for LOAD
//   q_next_o      register value after one step of op_i
module shift_step_logic
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [2:0]       op_i,
    input  logic             shift_in_r_i,
    input  logic             shift_in_l_i,
    input  logic [WIDTH-1:0] load_data_i,
    output logic [WIDTH-1:0] q_next_o
);

    always_comb begin
        q_next_o = q_i;
        unique case (op_i)
            OP_HOLD: q_next_o = q_i;
            OP_COMP: q_next_o = ~q_i;
            OP_SHR:  q_next_o = {shift_in_r_i, q_i[WIDTH-1:1]};
            OP_SHL:  q_next_o = {q_i[WIDTH-2:0], shift_in_l_i};
            OP_ROR:  q_next_o = {q_i[0], q_i[WIDTH-1:1]};
            OP_ROL:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            OP_ASR:  q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            OP_LOAD: q_next_o = load_data_i;
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register with a valid/ready command interface.
// HOLD/COMP/LOAD complete on the accept edge; shift/rotate ops run one step
// per clock for min(cmd_amt, WIDTH) steps.
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   cmd_valid / cmd_ready    command handshake (cmd_ready = ~busy)
//   cmd_op, cmd_amt          operation code and step count
//   load_data                parallel load value
//   shift_in_R, shift_in_L   serial inputs, sampled on every step edge
//   q                        register contents
//   serial_out_R/L           q[0] / q[WIDTH-1]
//   busy                     multi-step command still running
//   done                     one-cycle pulse after a command's final update
module universal_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8,  // must be >= 2
    localparam int unsigned AMT_W = amt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_in_R,
    input  logic             shift_in_L,
    output logic [WIDTH-1:0] q,
    output logic             serial_out_R,
    output logic             serial_out_L,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] q_q, q_d, step_q;
    logic [AMT_W-1:0] rem_q, rem_d, amt_eff;
    logic [2:0]       op_q, op_d, op_sel;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;

    assign accept  = cmd_valid & ~busy_q;
    assign amt_eff = (cmd_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : cmd_amt;
    // The first step uses the incoming op; later steps use the latched one.
    assign op_sel  = accept ? cmd_op : op_q;

    shift_step_logic #(
        .WIDTH(WIDTH)
    ) u_step (
        .q_i         (q_q),
        .op_i        (op_sel),
        .shift_in_r_i(shift_in_R),
        .shift_in_l_i(shift_in_L),
        .load_data_i (load_data),
        .q_next_o    (step_q)
    );

    always_comb begin
        q_d    = q_q;
        rem_d  = rem_q;
        busy_d = busy_q;
        op_d   = op_q;
        done_d = 1'b0;
        if (accept) begin
            op_d = cmd_op;
            if (!is_step_op(cmd_op)) begin
                q_d    = step_q;
                done_d = 1'b1;
            end else if (amt_eff == '0) begin
                done_d = 1'b1;
            end else begin
                q_d    = step_q;
                rem_d  = amt_eff - AMT_W'(1);
                busy_d = (amt_eff > AMT_W'(1));
                done_d = (amt_eff == AMT_W'(1));
            end
        end else if (busy_q) begin
            q_d    = step_q;
            rem_d  = rem_q - AMT_W'(1);
            busy_d = (rem_q > AMT_W'(1));
            done_d = (rem_q == AMT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q    <= '0;
            rem_q  <= '0;
            op_q   <= OP_HOLD;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            rem_q  <= rem_d;
            op_q   <= op_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign q            = q_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cmd_ready    = ~busy_q;
    assign serial_out_R = q_q[0];
    assign serial_out_L = q_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed test of universal_shift_reg at WIDTH=8 with hand-computed expectations.
module tb_universal_shift_reg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AMT_W = 4;

    localparam logic [2:0] HOLD = 3'b000, COMP = 3'b001, SHR = 3'b010, SHL = 3'b011;
    localparam logic [2:0] ROR = 3'b100, ROL = 3'b101, ASR = 3'b110, LOAD = 3'b111;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [AMT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] load_data;
    logic             shift_in_R, shift_in_L;
    logic [WIDTH-1:0] q;
    logic             serial_out_R, serial_out_L;
    logic             busy, done;

    int n_cmp = 0;
    int n_err = 0;

    universal_shift_reg #(
        .WIDTH(WIDTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_amt     (cmd_amt),
        .load_data   (load_data),
        .shift_in_R  (shift_in_R),
        .shift_in_L  (shift_in_L),
        .q           (q),
        .serial_out_R(serial_out_R),
        .serial_out_L(serial_out_L),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for exactly one edge, then withdraw it.
    task automatic issue(input logic [2:0] op, input logic [AMT_W-1:0] amt,
                         input logic [WIDTH-1:0] data);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = amt;
        load_data = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin : stim
        logic [WIDTH-1:0] exp_q [0:4];
        int n_done;
        int n_busy;

        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = HOLD;
        cmd_amt    = '0;
        load_data  = '0;
        shift_in_R = 1'b0;
        shift_in_L = 1'b0;
        tick();
        tick();
        @(negedge clk);
        reset_n = 1'b1;

        // Reset clears a loaded value and the pending done.
        issue(LOAD, 4'd0, 8'hFF);
        check_eq("preload_ff", q, 8'hFF);
        @(negedge clk);
        reset_n = 1'b0;
        tick();
        check_eq("rst_q", q, 8'h00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_ready", cmd_ready, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;

        // LOAD then COMP back to back.
        issue(LOAD, 4'd0, 8'hA5);
        check_eq("load_q", q, 8'hA5);
        check_eq("load_done", done, 1'b1);
        check_eq("load_busy", busy, 1'b0);
        check_eq("ser_r", serial_out_R, 1'b1);
        check_eq("ser_l", serial_out_L, 1'b1);
        issue(COMP, 4'd5, 8'h00);
        check_eq("comp_q", q, 8'h5A);
        check_eq("comp_done", done, 1'b1);
        check_eq("comp_busy", busy, 1'b0);
        issue(HOLD, 4'd3, 8'hFF);
        check_eq("hold_q", q, 8'h5A);
        check_eq("hold_done", done, 1'b1);
        tick();
        check_eq("done_drop", done, 1'b0);

        // SHR 3 with ones entering the MSB.
        issue(LOAD, 4'd0, 8'h81);
        shift_in_R = 1'b1;
        issue(SHR, 4'd3, 8'h00);
        check_eq("shr_s1", q, 8'hC0);
        check_eq("shr_busy1", busy, 1'b1);
        check_eq("shr_ready1", cmd_ready, 1'b0);
        check_eq("shr_done1", done, 1'b0);
        tick();
        check_eq("shr_s2", q, 8'hE0);
        check_eq("shr_busy2", busy, 1'b1);
        tick();
        check_eq("shr_s3", q, 8'hF0);
        check_eq("shr_busy3", busy, 1'b0);
        check_eq("shr_done3", done, 1'b1);
        tick();
        check_eq("shr_done_end", done, 1'b0);
        shift_in_R = 1'b0;

        // ROL 3.
        issue(LOAD, 4'd0, 8'h81);
        issue(ROL, 4'd3, 8'h00);
        check_eq("rol_s1", q, 8'h03);
        tick();
        check_eq("rol_s2", q, 8'h06);
        tick();
        check_eq("rol_s3", q, 8'h0C);
        check_eq("rol_done", done, 1'b1);

        // ASR 2 keeps the sign bit.
        issue(LOAD, 4'd0, 8'h90);
        issue(ASR, 4'd2, 8'h00);
        check_eq("asr_s1", q, 8'hC8);
        tick();
        check_eq("asr_s2", q, 8'hE4);
        check_eq("asr_done", done, 1'b1);

        // ROR 15 clamps to 8 steps and returns the original value.
        issue(LOAD, 4'd0, 8'h81);
        issue(ROR, 4'd15, 8'h00);
        check_eq("ror_s1", q, 8'hC0);
        n_done = int'(done);
        n_busy = int'(busy);
        for (int i = 0; i < 8; i++) begin
            tick();
            n_done += int'(done);
            n_busy += int'(busy);
        end
        check_eq("ror_q", q, 8'h81);
        check_eq("ror_done_cnt", n_done, 1);
        check_eq("ror_busy_cnt", n_busy, 7);

        // SHL 4 with a held SHL-0 request waiting behind it.
        issue(LOAD, 4'd0, 8'h01);
        shift_in_L = 1'b1;
        issue(SHL, 4'd4, 8'h00);
        check_eq("shl4_s1", q, 8'h03);
        cmd_valid = 1'b1;
        cmd_op    = SHL;
        cmd_amt   = 4'd0;
        exp_q[0] = 8'h07;
        exp_q[1] = 8'h0F;
        exp_q[2] = 8'h1F;
        exp_q[3] = 8'h1F;
        exp_q[4] = 8'h1F;
        n_done = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 2) check_eq("held_ready", cmd_ready, 1'b1);
            if (i == 3) begin
                check_eq("held_acc_done", done, 1'b1);
                check_eq("held_acc_busy", busy, 1'b0);
                cmd_valid = 1'b0;
            end
            check_eq($sformatf("held_q%0d", i), q, exp_q[i]);
            n_done += int'(done);
        end
        check_eq("held_done_cnt", n_done, 2);
        shift_in_L = 1'b0;

        // Reset aborts a SHL 5 at its third step edge.
        issue(LOAD, 4'd0, 8'h01);
        issue(SHL, 4'd5, 8'h00);
        check_eq("abort_s1", q, 8'h02);
        tick();
        check_eq("abort_s2", q, 8'h04);
        @(negedge clk);
        reset_n = 1'b0;
        tick();
        check_eq("abort_q", q, 8'h00);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_done += int'(done);
        end
        check_eq("abort_no_done", n_done, 0);
        issue(LOAD, 4'd0, 8'h3C);
        check_eq("after_abort_q", q, 8'h3C);
        check_eq("after_abort_done", done, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
